// File: rtl/fifo_reader_if.sv
// fifo_reader_if: downstream valid/ready word stream driven by fifo_reader.
//   o_valid  producer -> consumer   o_data holds a word
//   o_data   producer -> consumer   head-of-buffer word (DATA_WIDTH)
//   i_ready  consumer -> producer   consumer accepts o_data this cycle
// master = fifo_reader side, slave = consumer side.
interface fifo_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  i_ready;

  modport master (output o_valid, output o_data, input  i_ready);
  modport slave  (input  o_valid, input  o_data, output i_ready);
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: drains a non-showahead FIFO (data valid one cycle after rdreq)
// into a valid/ready stream. A 2-entry buffer (head/tail) absorbs the read
// latency, so a held-high i_ready with a non-empty FIFO moves one word per cycle.
// Ports:
//   clk, rst_n   clock (rising edge), synchronous active-low reset
//   fifo_empty   FIFO empty flag
//   fifo_q       FIFO read data, valid the cycle after fifo_rden
//   fifo_rden    FIFO read request (combinational)
//   i_flush      synchronous clear of buffer, in-flight read and counter
//   s            stream master: o_valid / o_data / i_ready
//   o_rd_count   words delivered, wraps (only when FIFO_RD_CNT_EN is defined)
// Optional feature: define FIFO_RD_CNT_EN to add the o_rd_count port/counter.
module fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  fifo_rden,
  input  logic                  i_flush,
  fifo_reader_if.master         s
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0]      o_rd_count
`endif
);

  if (DATA_WIDTH < 1) begin : g_bad_dw
    $error("fifo_reader: DATA_WIDTH must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cw
    $error("fifo_reader: CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;

  occ_e                  occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  pop;
  logic                  head_free;
  logic [2:0]            pend;

  assign s.o_valid = (occ_q != EMPTY);
  assign s.o_data  = head_q;

  always_comb begin
    pop  = s.o_valid & s.i_ready;
    // Words held or arriving after this edge; a new read must still fit.
    pend = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rden = ~fifo_empty & (pend < 3'd2) & rst_n & ~i_flush;

    // The arriving word lands in head only when head is vacant after the pop.
    head_free = (occ_q == EMPTY) | ((occ_q == ONE) & pop);

    occ_d      = occ_q;
    inflight_d = fifo_rden;
    head_d     = head_q;
    tail_d     = tail_q;

    if (pop) head_d = tail_q;
    if (inflight_q) begin
      if (head_free) head_d = fifo_q;
      else           tail_d = fifo_q;
    end

    unique case (occ_q)
      EMPTY: if (inflight_q) occ_d = ONE;
      ONE: begin
        if (inflight_q & ~pop)      occ_d = TWO;
        else if (pop & ~inflight_q) occ_d = EMPTY;
      end
      TWO:     if (pop & ~inflight_q) occ_d = ONE;
      default: occ_d = EMPTY;
    endcase

    // Flush wins over pop and capture; o_data keeps its last value.
    if (i_flush) begin
      occ_d      = EMPTY;
      inflight_d = 1'b0;
      head_d     = head_q;
      tail_d     = tail_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q      <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(pop);
    if (i_flush) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o_rd_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a behavioural non-showahead FIFO feeds the DUT;
// stimulus pushes each written word onto exp_q, and a negedge monitor
// compares every transferred word against exp_q in order. Flushes tell the
// monitor how many queued words the DUT legitimately discards.
module tb_fifo_reader;
`ifdef FIFO_RD_CNT_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_flush = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_q = 8'h00;
  logic       fifo_rden;
  logic       stall = 1'b0;
  logic       force_ne = 1'b0;
`ifdef FIFO_RD_CNT_EN
  logic [TB_CNT_W-1:0] o_rd_count;
`endif

  fifo_reader_if #(.DATA_WIDTH(8)) sif ();

  fifo_reader #(.DATA_WIDTH(8), .CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rden  (fifo_rden),
    .i_flush    (i_flush),
    .s          (sif)
`ifdef FIFO_RD_CNT_EN
    ,
    .o_rd_count (o_rd_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: stimulus owns wr_ptr/mem, the clocked read side owns rd_ptr.
  logic [7:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = force_ne ? 1'b0 : ((wr_ptr == rd_ptr) | stall);

  always @(posedge clk) begin
    if (fifo_rden && (wr_ptr != rd_ptr)) begin
      fifo_q <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Scoreboard
  logic [7:0] exp_q[$];
  int sb_idx = 0, skip_req = 0, skip_done = 0;
  int sb_tests = 0, sb_fails = 0;
  int d_tests = 0, d_fails = 0;

  always @(negedge clk) begin
    while (skip_done < skip_req) begin
      sb_idx++;
      skip_done++;
    end
    if (rst_n && !i_flush && sif.o_valid && sif.i_ready) begin
      sb_tests++;
      if (sb_idx >= exp_q.size()) begin
        sb_fails++;
        $display("FAIL stream_extra: got %02h, expected no word", sif.o_data);
      end else if (sif.o_data !== exp_q[sb_idx]) begin
        sb_fails++;
        $display("FAIL stream_order[%0d]: got %02h, expected %02h", sb_idx, sif.o_data, exp_q[sb_idx]);
      end
      sb_idx++;
    end
    if (rst_n && fifo_rden) begin
      sb_tests++;
      if (fifo_empty) begin
        sb_fails++;
        $display("FAIL rden_on_empty: fifo_rden=1 while fifo_empty=1");
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    d_tests++;
    if (act != expv) begin
      d_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (sb_idx < exp_q.size() && n < max_cyc) begin
      step();
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    sif.i_ready = 1'b0;

    // 1. Reset with FIFO claiming data: no read, outputs cleared.
    force_ne = 1'b1;
    repeat (2) begin
      step();
      @(negedge clk);
      chk("rst_rden", int'(fifo_rden), 0);
      chk("rst_valid", int'(sif.o_valid), 0);
      chk("rst_data", int'(sif.o_data), 0);
    end
    step();
    force_ne = 1'b0;
    rst_n = 1'b1;

    // 2. Three words, ready held: valid two cycles after first rden, no bubbles.
    step();
    rd0 = rd_ptr;
    sif.i_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    @(negedge clk);
    chk("lat_rden_n", int'(fifo_rden), 1);
    chk("lat_valid_n", int'(sif.o_valid), 0);
    step(); @(negedge clk);
    chk("lat_valid_n1", int'(sif.o_valid), 0);
    step(); @(negedge clk);
    chk("stream_w0", int'(sif.o_data), 'h11);
    step(); @(negedge clk);
    chk("stream_w1", int'(sif.o_data), 'h22);
    step(); @(negedge clk);
    chk("stream_w2", int'(sif.o_data), 'h33);
    chk("stream_w2_valid", int'(sif.o_valid), 1);
    step(); @(negedge clk);
    chk("stream_end_valid", int'(sif.o_valid), 0);
    chk("stream_rden_cnt", rd_ptr - rd0, 3);

    // 3. Backpressure: two reads only, head stable; release drains in order.
    sif.i_ready = 1'b0;
    step();
    rd0 = rd_ptr;
    for (int i = 1; i <= 5; i++) push(8'hA0 + 8'(i));
    repeat (6) step();
    @(negedge clk);
    chk("bp_rden_cnt", rd_ptr - rd0, 2);
    chk("bp_valid", int'(sif.o_valid), 1);
    chk("bp_head_a", int'(sif.o_data), 'hA1);
    step(); @(negedge clk);
    chk("bp_head_b", int'(sif.o_data), 'hA1);
    step();
    sif.i_ready = 1'b1;
    wait_drain(30);
    chk("bp_drained", sb_idx, exp_q.size());

    // 4. Flush with one word held and one in flight after a single pop.
    sif.i_ready = 1'b0;
    step();
    for (int i = 1; i <= 6; i++) push(8'hB0 + 8'(i));
    repeat (5) step();
    sif.i_ready = 1'b1;          // pops B1, reads B3
    step();
    sif.i_ready = 1'b0;
    i_flush = 1'b1;              // drops B2 (held) and B3 (in flight)
    skip_req = skip_req + 2;
    @(negedge clk);
    chk("flush_rden", int'(fifo_rden), 0);
    step();
    i_flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", int'(sif.o_valid), 0);
    chk("flush_data_held", int'(sif.o_data), 'hB2);
    step();
    sif.i_ready = 1'b1;
    step(); @(negedge clk);
    chk("flush_next_word", int'(sif.o_data), 'hB4);
    wait_drain(30);
    chk("flush_drained", sb_idx, exp_q.size());

    // 5. Random ready and FIFO gaps against the scoreboard.
    for (int c = 0; c < 10000; c++) begin
      step();
      sif.i_ready = ($urandom_range(3) != 0);
      stall = ($urandom_range(2) == 0);
      if ((wr_ptr - rd_ptr) < 100 && $urandom_range(1) == 1)
        push(8'($urandom));
    end
    step();
    stall = 1'b0;
    sif.i_ready = 1'b1;
    wait_drain(300);
    chk("rand_drained", sb_idx, exp_q.size());

`ifdef FIFO_RD_CNT_EN
    // 6. Counter wrap at CNT_W=4 and clear on flush.
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    @(negedge clk);
    chk("cnt_flush0", int'(o_rd_count), 0);
    for (int i = 0; i < 17; i++) push(8'hC0 + 8'(i));
    wait_drain(60);
    step(); step();
    @(negedge clk);
    chk("cnt_wrap", int'(o_rd_count), 1);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    @(negedge clk);
    chk("cnt_flush1", int'(o_rd_count), 0);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", d_tests + sb_tests, d_fails + sb_fails);
    $finish;
  end
endmodule
